// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC channel scanner.
// Provides the FSM state enum, default widths and the accumulator width helper.
package adc_scan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      ADVANCE,
      PUBLISH
   } scan_state_t;

   localparam int DEF_CH_W   = 5;
   localparam int DEF_DATA_W = 12;

   // Summing 2^avg_log2 samples of data_w bits needs avg_log2 extra bits.
   function automatic int acc_width(input int data_w, input int avg_log2);
      return data_w + avg_log2;
   endfunction

endpackage

// File: rtl/adc_scan_accum.sv
// Per-channel accumulator bank: adds one sample into slot add_idx,
// clears all slots on clear, and presents every slot shifted right by AVG_LOG2.
// Ports: clk, rst, clear, add_en/add_idx/add_data (accumulate), avg (packed averages).
module adc_scan_accum
   import adc_scan_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int AVG_LOG2 = 2,
   parameter int IDX_W    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     add_en,
   input  logic [IDX_W-1:0]         add_idx,
   input  logic [DATA_W-1:0]        add_data,
   output logic [NUM_CH*DATA_W-1:0] avg
);

   localparam int ACC_W = acc_width(DATA_W, AVG_LOG2);

   logic [ACC_W-1:0] acc [NUM_CH];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
         end
      end else if (add_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (add_idx == IDX_W'(i)) begin
               acc[i] <= acc[i] + ACC_W'(add_data);
            end
         end
      end
   end

   // Truncating divide by the number of rounds.
   always_comb begin
      avg = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         avg[i*DATA_W +: DATA_W] = DATA_W'(acc[i] >> AVG_LOG2);
      end
   end

endmodule

// File: rtl/adc_channel_scanner.sv
// Round-robin ADC sequencer: issues one command at a time, oversamples each
// channel, publishes an averaged vector with a valid pulse and sequence count.
// Ports: clock_clk, reset_sink_reset, enable, clear_err; command_* (to ADC);
// response_* (from ADC); sample_data/valid/seq (to game logic); err_timeout/channel.
module adc_channel_scanner
   import adc_scan_pkg::*;
#(
   parameter int                     NUM_CH      = 2,
   parameter int                     CH_W        = DEF_CH_W,
   parameter int                     DATA_W      = DEF_DATA_W,
   parameter logic [NUM_CH*CH_W-1:0] CH_MAP      = {5'd2, 5'd1},
   parameter int                     AVG_LOG2    = 2,
   parameter int                     TIMEOUT_CYC = 1023
) (
   input  logic                     clock_clk,
   input  logic                     reset_sink_reset,
   input  logic                     enable,
   input  logic                     clear_err,
   output logic                     command_valid,
   output logic [CH_W-1:0]          command_channel,
   output logic                     command_startofpacket,
   output logic                     command_endofpacket,
   input  logic                     command_ready,
   input  logic                     response_valid,
   input  logic [CH_W-1:0]          response_channel,
   input  logic [DATA_W-1:0]        response_data,
   output logic [NUM_CH*DATA_W-1:0] sample_data,
   output logic                     sample_valid,
   output logic [7:0]               sample_seq,
   output logic                     err_timeout,
   output logic                     err_channel
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int RND_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
   localparam logic [RND_W-1:0] LAST_RND = RND_W'((1 << AVG_LOG2) - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   scan_state_t state;
   scan_state_t nstate;

   logic [IDX_W-1:0]         idx;
   logic [RND_W-1:0]         rnd;
   logic [TMO_W-1:0]         tmo_cnt;
   logic [CH_W-1:0]          cur_ch;
   logic [NUM_CH*DATA_W-1:0] acc_avg;

   logic last_idx;
   logic last_rnd;
   logic resp_ok;
   logic resp_bad;
   logic tmo_hit;
   logic pub_go;
   logic acc_clear;

   // CH_MAP lists slot 0 first, i.e. in the most significant field.
   always_comb begin
      cur_ch = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_ch = CH_MAP[(NUM_CH-1-i)*CH_W +: CH_W];
         end
      end
   end

   assign last_idx = (idx == LAST_IDX);
   assign last_rnd = (rnd == LAST_RND);

   assign resp_ok  = response_valid && (state == WAIT) &&
                     (response_channel == cur_ch);
   assign resp_bad = response_valid && !resp_ok;

   // A response arriving in the same cycle always beats the timeout.
   assign tmo_hit  = (state == WAIT) && !response_valid &&
                     (tmo_cnt == TMO_LAST);

   assign pub_go   = (state == ADVANCE) && last_idx && last_rnd;

   // Dropping out of a round to IDLE throws away the partial sums.
   assign acc_clear = (state == IDLE) || (state == PUBLISH) ||
                      ((state == ADVANCE) && !pub_go && !enable);

   always_comb begin
      nstate                = state;
      command_valid         = 1'b0;
      command_channel       = '0;
      command_startofpacket = 1'b0;
      command_endofpacket   = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable) nstate = ISSUE;
         end
         ISSUE: begin
            command_valid         = 1'b1;
            command_channel       = cur_ch;
            command_startofpacket = (idx == '0);
            command_endofpacket   = last_idx;
            if (command_ready) nstate = WAIT;
         end
         WAIT: begin
            if (resp_ok) nstate = ADVANCE;
            else if (response_valid || tmo_hit) nstate = ISSUE;
         end
         ADVANCE: begin
            if (pub_go) nstate = PUBLISH;
            else if (enable) nstate = ISSUE;
            else nstate = IDLE;
         end
         PUBLISH: begin
            nstate = enable ? ISSUE : IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clock_clk) begin
      if (reset_sink_reset) begin
         state        <= IDLE;
         idx          <= '0;
         rnd          <= '0;
         tmo_cnt      <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         sample_seq   <= '0;
         err_timeout  <= 1'b0;
         err_channel  <= 1'b0;
      end else begin
         state <= nstate;

         // Outputs are registered on entry to PUBLISH so the pulse,
         // data and count all appear together in that cycle.
         sample_valid <= pub_go;
         if (pub_go) begin
            sample_data <= acc_avg;
            sample_seq  <= sample_seq + 8'd1;
         end

         unique case (state)
            IDLE: begin
               idx <= '0;
               rnd <= '0;
            end
            ISSUE: tmo_cnt <= '0;
            WAIT:  tmo_cnt <= tmo_cnt + 1'b1;
            ADVANCE: begin
               if (!last_idx) begin
                  idx <= idx + 1'b1;
               end else begin
                  idx <= '0;
                  if (!last_rnd) rnd <= rnd + 1'b1;
               end
               if (!pub_go && !enable) begin
                  idx <= '0;
                  rnd <= '0;
               end
            end
            PUBLISH: rnd <= '0;
            default: ;
         endcase

         // Set beats clear when both happen together.
         if (resp_bad) err_channel <= 1'b1;
         else if (clear_err) err_channel <= 1'b0;

         if (tmo_hit) err_timeout <= 1'b1;
         else if (clear_err) err_timeout <= 1'b0;
      end
   end

   adc_scan_accum #(
      .NUM_CH   (NUM_CH),
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2),
      .IDX_W    (IDX_W)
   ) u_accum (
      .clk      (clock_clk),
      .rst      (reset_sink_reset),
      .clear    (acc_clear),
      .add_en   (resp_ok),
      .add_idx  (idx),
      .add_data (response_data),
      .avg      (acc_avg)
   );

endmodule

// File: tb/tb_adc_channel_scanner.sv
// Bench for adc_channel_scanner: scripted ADC responder plus publish scoreboard.
// Each scenario task drives stimulus and compares observed against expected.
module tb_adc_channel_scanner;

   localparam int TMO = 15;

   logic        clock_clk = 1'b0;
   logic        reset_sink_reset = 1'b1;
   logic        enable = 1'b0;
   logic        clear_err = 1'b0;
   logic        command_valid;
   logic [4:0]  command_channel;
   logic        command_startofpacket;
   logic        command_endofpacket;
   logic        command_ready;
   logic        response_valid;
   logic [4:0]  response_channel;
   logic [11:0] response_data;
   logic [23:0] sample_data;
   logic        sample_valid;
   logic [7:0]  sample_seq;
   logic        err_timeout;
   logic        err_channel;

   always #5 clock_clk = ~clock_clk;

   adc_channel_scanner #(
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clock_clk             (clock_clk),
      .reset_sink_reset      (reset_sink_reset),
      .enable                (enable),
      .clear_err             (clear_err),
      .command_valid         (command_valid),
      .command_channel       (command_channel),
      .command_startofpacket (command_startofpacket),
      .command_endofpacket   (command_endofpacket),
      .command_ready         (command_ready),
      .response_valid        (response_valid),
      .response_channel      (response_channel),
      .response_data         (response_data),
      .sample_data           (sample_data),
      .sample_valid          (sample_valid),
      .sample_seq            (sample_seq),
      .err_timeout           (err_timeout),
      .err_channel           (err_channel)
   );

   typedef struct {
      bit          drop;
      logic [4:0]  ch;
      logic [11:0] data;
   } plan_t;

   typedef struct {
      logic [4:0] ch;
      logic       sop;
      logic       eop;
   } cmd_t;

   typedef struct {
      logic [11:0] s0;
      logic [11:0] s1;
      logic [7:0]  seq;
   } pub_t;

   plan_t plan_q[$];
   cmd_t  cmd_log[$];
   pub_t  exp_q[$];
   pub_t  got_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int stall_total = 0;
   int stray_cnt = 0;

   // ADC model: one scripted reply per accepted command, optional
   // ready stalls and stray responses; also captures every publish.
   initial begin : responder
      bit    hs;
      bit    pend;
      int    stray_done;
      int    stall_used;
      cmd_t  hs_cmd;
      plan_t cur;
      pub_t  p;
      hs = 0;
      pend = 0;
      stray_done = 0;
      stall_used = 0;
      command_ready = 1'b1;
      response_valid = 1'b0;
      response_channel = '0;
      response_data = '0;
      forever begin
         @(negedge clock_clk);
         response_valid = 1'b0;
         if (sample_valid) begin
            p.s0 = sample_data[11:0];
            p.s1 = sample_data[23:12];
            p.seq = sample_seq;
            got_q.push_back(p);
         end
         if (reset_sink_reset) begin
            hs = 0;
            pend = 0;
         end
         if (hs) begin
            cmd_log.push_back(hs_cmd);
            if (plan_q.size() > 0) cur = plan_q.pop_front();
            else cur.drop = 1;
            pend = !cur.drop;
         end
         if (pend) begin
            response_valid = 1'b1;
            response_channel = cur.ch;
            response_data = cur.data;
            pend = 0;
         end else if (stray_done != stray_cnt) begin
            response_valid = 1'b1;
            response_channel = 5'd2;
            response_data = 12'habc;
            stray_done++;
         end
         if (command_valid && stall_used < stall_total) begin
            command_ready = 1'b0;
            stall_used++;
         end else begin
            command_ready = 1'b1;
         end
         hs = command_valid && command_ready && !reset_sink_reset;
         hs_cmd.ch = command_channel;
         hs_cmd.sop = command_startofpacket;
         hs_cmd.eop = command_endofpacket;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock_clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      clear_err = 1'b0;
      reset_sink_reset = 1'b1;
      tick();
      tick();
      plan_q.delete();
      cmd_log.delete();
      exp_q.delete();
      got_q.delete();
      reset_sink_reset = 1'b0;
      tick();
   endtask

   task automatic plan_add(input bit drop, input int ch, input int data);
      plan_t e;
      e.drop = drop;
      e.ch = 5'(ch);
      e.data = 12'(data);
      plan_q.push_back(e);
   endtask

   task automatic exp_add(input int s0, input int s1, input int seq);
      pub_t e;
      e.s0 = 12'(s0);
      e.s1 = 12'(s1);
      e.seq = 8'(seq);
      exp_q.push_back(e);
   endtask

   task automatic run_cmds(input int n, output bit ok);
      int k;
      k = 0;
      while (cmd_log.size() < n && k < 400) begin
         tick();
         k++;
      end
      ok = (cmd_log.size() >= n);
   endtask

   task automatic wait_pub(output bit ok);
      int k;
      k = 0;
      while (got_q.size() == 0 && k < 50) begin
         tick();
         k++;
      end
      ok = (got_q.size() > 0);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({command_valid, command_channel, command_startofpacket,
           command_endofpacket, sample_data, sample_valid, sample_seq,
           err_timeout, err_channel} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: valid=%0b ch=%0d data=%h seq=%0d et=%0b ec=%0b required all 0",
                  command_valid, command_channel, sample_data, sample_seq,
                  err_timeout, err_channel);
      end
      repeat (5) tick();
      n_cmp++;
      if (command_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_quiet: command_valid=%0b required 0", command_valid);
      end
   endtask

   task automatic test_basic();
      int d2[4] = '{100, 104, 108, 112};
      int s2;
      bit ok;
      pub_t g;
      pub_t e;
      do_reset();
      s2 = 0;
      for (int r = 0; r < 4; r++) begin
         plan_add(0, 2, d2[r]);
         plan_add(0, 1, 4095);
         s2 += d2[r];
      end
      exp_add(s2 >> 2, 4095, 1);
      enable = 1'b1;
      run_cmds(8, ok);
      enable = 1'b0;
      wait_pub(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL basic_pub: no sample_valid seen, required 1 pulse");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.s0 !== e.s0 || g.s1 !== e.s1 || g.seq !== e.seq) begin
            n_bad++;
            $display("FAIL basic_data: got %0d/%0d seq %0d required %0d/%0d seq %0d",
                     g.s0, g.s1, g.seq, e.s0, e.s1, e.seq);
         end
      end
      repeat (6) tick();
      n_cmp++;
      if (got_q.size() !== 0 || cmd_log.size() !== 8) begin
         n_bad++;
         $display("FAIL basic_count: pulses %0d cmds %0d required 0 extra / 8",
                  got_q.size(), cmd_log.size());
      end
      for (int i = 0; i < cmd_log.size() && i < 8; i++) begin
         n_cmp++;
         if (cmd_log[i].ch !== ((i % 2 == 0) ? 5'd2 : 5'd1) ||
             cmd_log[i].sop !== (i % 2 == 0) ||
             cmd_log[i].eop !== (i % 2 == 1)) begin
            n_bad++;
            $display("FAIL basic_cmd%0d: ch=%0d sop=%0b eop=%0b required ch=%0d",
                     i, cmd_log[i].ch, cmd_log[i].sop, cmd_log[i].eop,
                     (i % 2 == 0) ? 2 : 1);
         end
      end
   endtask

   task automatic test_ready_stall();
      int k;
      int hi;
      do_reset();
      plan_add(0, 2, 7);
      stall_total += 5;
      enable = 1'b1;
      k = 0;
      while (!command_valid && k < 20) begin
         tick();
         k++;
      end
      hi = 0;
      while (command_valid && hi < 20) begin
         n_cmp++;
         if (command_channel !== 5'd2 || cmd_log.size() !== 0) begin
            n_bad++;
            $display("FAIL stall_hold%0d: ch=%0d cmds=%0d required ch=2 cmds=0",
                     hi, command_channel, cmd_log.size());
         end
         hi++;
         tick();
      end
      enable = 1'b0;
      n_cmp++;
      if (hi !== 6) begin
         n_bad++;
         $display("FAIL stall_cycles: valid high %0d cycles required 6", hi);
      end
      tick();
      n_cmp++;
      if (cmd_log.size() !== 1) begin
         n_bad++;
         $display("FAIL stall_accept: cmds %0d required 1", cmd_log.size());
      end
   endtask

   task automatic test_timeout();
      int ech[9] = '{2, 1, 1, 2, 1, 2, 1, 2, 1};
      int s2;
      int s1;
      int k;
      bit ok;
      pub_t g;
      pub_t e;
      do_reset();
      s2 = 0;
      s1 = 0;
      for (int r = 0; r < 4; r++) begin
         plan_add(0, 2, 200 + 4 * r);
         if (r == 0) plan_add(1, 1, 0);
         plan_add(0, 1, 1000 + 4 * r);
         s2 += 200 + 4 * r;
         s1 += 1000 + 4 * r;
      end
      exp_add(s2 >> 2, s1 >> 2, 1);
      enable = 1'b1;
      run_cmds(2, ok);
      k = 0;
      while (!err_timeout && k < 40) begin
         tick();
         k++;
      end
      n_cmp++;
      if (!err_timeout || k < 12 || k > 18) begin
         n_bad++;
         $display("FAIL timeout_flag: err_timeout=%0b after %0d cycles required 1 after about %0d",
                  err_timeout, k, TMO);
      end
      run_cmds(9, ok);
      enable = 1'b0;
      wait_pub(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL timeout_pub: no sample_valid seen, required 1 pulse");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.s0 !== e.s0 || g.s1 !== e.s1 || g.seq !== e.seq) begin
            n_bad++;
            $display("FAIL timeout_data: got %0d/%0d seq %0d required %0d/%0d seq %0d",
                     g.s0, g.s1, g.seq, e.s0, e.s1, e.seq);
         end
      end
      for (int i = 0; i < cmd_log.size() && i < 9; i++) begin
         n_cmp++;
         if (cmd_log[i].ch !== 5'(ech[i])) begin
            n_bad++;
            $display("FAIL timeout_cmd%0d: ch=%0d required %0d",
                     i, cmd_log[i].ch, ech[i]);
         end
      end
   endtask

   task automatic test_chan_err();
      int ech[9] = '{2, 1, 1, 2, 1, 2, 1, 2, 1};
      int s2;
      int s1;
      bit ok;
      pub_t g;
      pub_t e;
      do_reset();
      s2 = 0;
      s1 = 0;
      for (int r = 0; r < 4; r++) begin
         plan_add(0, 2, 300 + r);
         if (r == 0) plan_add(0, 7, 555);
         plan_add(0, 1, 50 + 10 * r);
         s2 += 300 + r;
         s1 += 50 + 10 * r;
      end
      exp_add(s2 >> 2, s1 >> 2, 1);
      enable = 1'b1;
      run_cmds(9, ok);
      enable = 1'b0;
      wait_pub(ok);
      n_cmp++;
      if (err_channel !== 1'b1 || err_timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL chan_flag: err_channel=%0b err_timeout=%0b required 1/0",
                  err_channel, err_timeout);
      end
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL chan_pub: no sample_valid seen, required 1 pulse");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.s0 !== e.s0 || g.s1 !== e.s1 || g.seq !== e.seq) begin
            n_bad++;
            $display("FAIL chan_data: got %0d/%0d seq %0d required %0d/%0d seq %0d",
                     g.s0, g.s1, g.seq, e.s0, e.s1, e.seq);
         end
      end
      for (int i = 0; i < cmd_log.size() && i < 9; i++) begin
         n_cmp++;
         if (cmd_log[i].ch !== 5'(ech[i])) begin
            n_bad++;
            $display("FAIL chan_cmd%0d: ch=%0d required %0d",
                     i, cmd_log[i].ch, ech[i]);
         end
      end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      n_cmp++;
      if (err_channel !== 1'b0) begin
         n_bad++;
         $display("FAIL chan_clear: err_channel=%0b required 0", err_channel);
      end
   endtask

   task automatic test_enable_drop();
      int s2;
      int s1;
      bit ok;
      pub_t g;
      pub_t e;
      do_reset();
      for (int r = 0; r < 4; r++) begin
         plan_add(0, 2, 10 * (r + 1));
         plan_add(0, 1, r + 1);
      end
      exp_add(25, 2, 1);
      plan_add(0, 2, 4000);
      plan_add(0, 1, 4000);
      plan_add(0, 2, 4000);
      s2 = 0;
      s1 = 0;
      for (int r = 0; r < 4; r++) begin
         plan_add(0, 2, 1000 + r);
         plan_add(0, 1, 2000 + 2 * r);
         s2 += 1000 + r;
         s1 += 2000 + 2 * r;
      end
      exp_add(s2 >> 2, s1 >> 2, 2);
      enable = 1'b1;
      run_cmds(11, ok);
      enable = 1'b0;
      repeat (12) tick();
      n_cmp++;
      if (got_q.size() !== 1) begin
         n_bad++;
         $display("FAIL drop_pulses: %0d publishes required 1", got_q.size());
      end
      if (got_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.s0 !== e.s0 || g.s1 !== e.s1 || g.seq !== e.seq) begin
            n_bad++;
            $display("FAIL drop_first: got %0d/%0d seq %0d required %0d/%0d seq %0d",
                     g.s0, g.s1, g.seq, e.s0, e.s1, e.seq);
         end
      end
      n_cmp++;
      if (command_valid !== 1'b0 || cmd_log.size() !== 11 ||
          sample_data !== {12'd2, 12'd25} || sample_seq !== 8'd1) begin
         n_bad++;
         $display("FAIL drop_idle: valid=%0b cmds=%0d data=%h seq=%0d required 0/11/002019/1",
                  command_valid, cmd_log.size(), sample_data, sample_seq);
      end
      enable = 1'b1;
      run_cmds(18, ok);
      n_cmp++;
      if (got_q.size() !== 0) begin
         n_bad++;
         $display("FAIL drop_early: %0d publishes before round 4 required 0",
                  got_q.size());
      end
      run_cmds(19, ok);
      enable = 1'b0;
      wait_pub(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL drop_pub: no sample_valid seen, required 1 pulse");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.s0 !== e.s0 || g.s1 !== e.s1 || g.seq !== e.seq) begin
            n_bad++;
            $display("FAIL drop_second: got %0d/%0d seq %0d required %0d/%0d seq %0d",
                     g.s0, g.s1, g.seq, e.s0, e.s1, e.seq);
         end
      end
   endtask

   task automatic test_reset_wait();
      bit ok;
      pub_t g;
      pub_t e;
      do_reset();
      for (int r = 0; r < 4; r++) begin
         plan_add(0, 2, 400);
         plan_add(0, 1, 800);
      end
      exp_add(400, 800, 1);
      plan_add(1, 0, 0);
      enable = 1'b1;
      run_cmds(9, ok);
      wait_pub(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL rstw_pub: no sample_valid seen, required 1 pulse");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (g.s0 !== e.s0 || g.s1 !== e.s1 || g.seq !== e.seq) begin
            n_bad++;
            $display("FAIL rstw_data: got %0d/%0d seq %0d required %0d/%0d seq %0d",
                     g.s0, g.s1, g.seq, e.s0, e.s1, e.seq);
         end
      end
      tick();
      reset_sink_reset = 1'b1;
      stray_cnt++;
      tick();
      n_cmp++;
      if ({command_valid, command_channel, command_startofpacket,
           command_endofpacket, sample_data, sample_valid, sample_seq,
           err_timeout, err_channel} !== '0) begin
         n_bad++;
         $display("FAIL rstw_outputs: valid=%0b data=%h seq=%0d et=%0b ec=%0b required all 0",
                  command_valid, sample_data, sample_seq, err_timeout,
                  err_channel);
      end
      tick();
      enable = 1'b0;
      reset_sink_reset = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (err_channel !== 1'b0 || command_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rstw_late: err_channel=%0b valid=%0b required 0/0",
                  err_channel, command_valid);
      end
      stray_cnt++;
      repeat (2) tick();
      n_cmp++;
      if (err_channel !== 1'b1) begin
         n_bad++;
         $display("FAIL rstw_stray: err_channel=%0b required 1", err_channel);
      end
      clear_err = 1'b1;
      stray_cnt++;
      tick();
      clear_err = 1'b0;
      tick();
      n_cmp++;
      if (err_channel !== 1'b1) begin
         n_bad++;
         $display("FAIL rstw_set_wins: err_channel=%0b required 1", err_channel);
      end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      n_cmp++;
      if (err_channel !== 1'b0) begin
         n_bad++;
         $display("FAIL rstw_clear: err_channel=%0b required 0", err_channel);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ready_stall();
      test_timeout();
      test_chan_err();
      test_enable_drop();
      test_reset_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_channel_scanner.md
Name: adc_channel_scanner

Overview:
- Autonomous sequencer that drives the modular-ADC command/response Avalon-ST sequencer interface, replacing the fixed 2-channel joystick wrapper.
- Scans NUM_CH configurable ADC channels round-robin and oversamples each 2^AVG_LOG2 times.
- Publishes one averaged, atomically updated vector of all channels, with a valid pulse, to game logic (joystick, paddles).
- Adds timeout recovery and channel-mismatch detection, which the plain ADC core lacks.

Parameters:
- NUM_CH, 2, number of channels scanned per round (1..8).
- CH_W, 5, ADC channel-number width.
- DATA_W, 12, ADC sample width.
- CH_MAP, {5'd2,5'd1}, packed NUM_CH*CH_W list; slot i = ADC channel for scan index i.
- AVG_LOG2, 2, log2 of rounds averaged per published sample (0..6).
- TIMEOUT_CYC, 1023, cycles allowed in WAIT before giving up on a response.

Ports:
- clock_clk  in  1  system clock; single clock domain.
- reset_sink_reset  in  1  synchronous, active-high reset.
- enable  in  1  level; scanning runs while high.
- clear_err  in  1  one-cycle pulse; clears sticky error flags.
- command_valid  out  1  command handshake valid.
- command_channel  out  CH_W  channel to convert.
- command_startofpacket  out  1  high when scan index is 0.
- command_endofpacket  out  1  high when scan index is NUM_CH-1.
- command_ready  in  1  ADC accepts command.
- response_valid  in  1  conversion result valid.
- response_channel  in  CH_W  channel of result.
- response_data  in  DATA_W  conversion result.
- sample_data  out  NUM_CH*DATA_W  averaged results; slot i at [i*DATA_W +: DATA_W].
- sample_valid  out  1  one-cycle pulse when sample_data updates.
- sample_seq  out  8  publish counter; wraps 255->0.
- err_timeout  out  1  sticky; a response timed out.
- err_channel  out  1  sticky; response channel mismatch or stray response.

Behaviour:
- Reset: state IDLE; all outputs 0; idx, round, timeout counter and accumulators cleared. Reset takes priority in any state, including mid-handshake.
- Handshake: one outstanding command only. Once command_valid rises, it and channel/sop/eop hold stable until command_ready.
- States:
  - IDLE: outputs quiet. enable=1 -> ISSUE with idx=0, round=0.
  - ISSUE: command_valid=1, command_channel=CH_MAP[idx]. command_ready -> WAIT, timeout counter=0.
  - WAIT: counter increments each cycle.
    - response_valid with response_channel==CH_MAP[idx]: acc[idx] += response_data, then ADVANCE.
    - response_valid with any other channel: err_channel=1, data discarded, -> ISSUE same idx.
    - counter reaches TIMEOUT_CYC without a response: err_timeout=1 -> ISSUE same idx.
    - Response and timeout in the same cycle: the response wins.
  - ADVANCE (1 cycle):
    - idx<NUM_CH-1: idx++.
    - Otherwise idx=0, and either round==2^AVG_LOG2-1 -> PUBLISH, or round++.
    - Not going to PUBLISH: enable=1 -> ISSUE; enable=0 -> IDLE.
  - PUBLISH (1 cycle): sample_data slot i <= acc[i] >> AVG_LOG2 (truncating); sample_valid=1; sample_seq++; all acc and round cleared. Then enable=1 -> ISSUE, enable=0 -> IDLE.
- Arithmetic: acc width DATA_W+AVG_LOG2; cannot overflow. All slots of sample_data change in the same cycle; they hold between publishes.
- enable falling mid-operation: the in-flight command/response completes. Entering IDLE from ADVANCE discards the partial round (acc and round cleared); sample_data is untouched.
- response_valid outside WAIT: ignored, err_channel=1.
- clear_err: clears both error flags next cycle. clear_err and an error event in the same cycle: the flag ends set.
- Latency: the publish pulse comes 2 cycles after the final accepted response (ADVANCE, then PUBLISH registered).

Decomposition:
- Package adc_scan_pkg:
  - state enum {IDLE, ISSUE, WAIT, ADVANCE, PUBLISH};
  - default CH_W/DATA_W constants;
  - function returning acc width from DATA_W and AVG_LOG2.
- Sub-module adc_scan_accum: NUM_CH accumulator bank with add(idx,data), clear and shift-out. The top keeps the FSM, handshake, timeout and error logic.

Test Plan:
- Defaults; responder replies ch2=100,104,108,112 and ch1=4095 x4; enable=1 -> one sample_valid pulse; slot0=106, slot1=4095; sample_seq=1; commands alternate 2,1 with sop on ch2 and eop on ch1.
- command_ready held low 5 cycles -> command_valid and command_channel=2 stable for all 5 cycles; WAIT entered only after ready.
- TIMEOUT_CYC=15, drop the first ch1 response -> err_timeout=1 after 15 cycles; ch1 reissued; next publish averages 4 valid samples only.
- Respond with channel 7 while expecting 1 -> err_channel=1, sample discarded, ch1 reissued; clear_err pulse -> flag 0 next cycle.
- enable dropped during round 2 -> current response accepted, FSM reaches IDLE, no sample_valid, sample_data unchanged; re-enable -> full 4 rounds before next publish.
- Reset asserted while in WAIT -> next cycle all outputs 0, state IDLE; late response_valid ignored (err_channel stays 0 because reset cleared it; only post-reset strays set it).
